// File: rtl/param_ram.sv
// Single-port byte-writable RAM with an optional full-array clear sequencer.
// Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); writes land on the accepting edge.
// Backpressure: ready is low for the DEPTH cycles of a clear; requests seen then are dropped.
module param_ram #(
  parameter int unsigned        DATA_W         = 16,
  parameter int unsigned        ADDR_W         = 6,
  parameter int unsigned        OUT_REG        = 0,
  parameter int unsigned        CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  r,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  clr,
  output logic                  ready,
  output logic [DATA_W-1:0]     out,
  output logic                  out_valid
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // State held while rst_n is low: clear pending if a power-on clear is wanted.
  localparam state_e RST_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;

  // Storage is never reset; a clear sweep is the only way to give it known contents.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Request qualification. clr takes priority over en in IDLE, so a request
  // coinciding with a clear command is dropped rather than executed.
  logic                acc;
  logic                acc_rd;
  logic                acc_wr;
  logic [DATA_W-1:0]   rd_dat;

  assign ready  = (state_q == ST_IDLE);
  assign acc    = ready & en & ~clr;
  assign acc_rd = acc & r;
  assign acc_wr = acc & ~r;
  assign rd_dat = mem[address];

  // Write port mux: the clear sweep owns the port in CLEAR, user writes in IDLE.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NBYTES-1:0]   mem_wbe;

  // Select write source and byte mask for this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = data;
    mem_wbe   = be;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = INIT_VAL;
      mem_wbe   = '1;
    end else if (acc_wr) begin
      mem_we    = 1'b1;
    end
  end

  // Byte-masked memory write; a write with an all-zero mask leaves the word intact.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (mem_wbe[k]) begin
          mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Clear/idle sequencer: CLEAR sweeps every address once, then returns to IDLE
  // on the edge that writes the last word. clr is not sampled while clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_ST;
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          clr_cnt_q <= '0;
        end
      endcase
    end
  end

  // Output register; holds its value between reads so out never floats.
  logic [DATA_W-1:0]   out_q;
  logic [DATA_W-1:0]   out_d;
  logic                out_valid_q;
  logic                out_valid_d;

  assign out       = out_q;
  assign out_valid = out_valid_q;

  if (OUT_REG != 0) begin : g_oreg
    // Extra stage between the array and the output register. A read captured
    // here before a clear starts still drains with its pre-clear data.
    logic [DATA_W-1:0] pipe_dat_q;
    logic [DATA_W-1:0] pipe_dat_d;
    logic              pipe_vld_q;
    logic              pipe_vld_d;

    // Next-state for the pipeline stage and the output register.
    always_comb begin
      pipe_vld_d  = acc_rd;
      pipe_dat_d  = pipe_dat_q;
      if (acc_rd) begin
        pipe_dat_d = rd_dat;
      end
      out_valid_d = pipe_vld_q;
      out_d       = out_q;
      if (pipe_vld_q) begin
        out_d = pipe_dat_q;
      end
    end

    // Pipeline stage and output registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_dat_q  <= '0;
        pipe_vld_q  <= 1'b0;
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        pipe_dat_q  <= pipe_dat_d;
        pipe_vld_q  <= pipe_vld_d;
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
      end
    end
  end else begin : g_direct
    // Next-state for the output register: load array data on an accepted read.
    always_comb begin
      out_valid_d = acc_rd;
      out_d       = out_q;
      if (acc_rd) begin
        out_d = rd_dat;
      end
    end

    // Output registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
      end
    end
  end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter ADDR_W, default 6, address width; DEPTH SHALL equal 2**ADDR_W words.
REQ-003 Parameter OUT_REG, default 0, read latency select: 0 gives 1 cycle, 1 gives 2 cycles.
REQ-004 Parameter CLEAR_ON_RESET, default 1; 1 SHALL start a full-array clear after reset release.
REQ-005 Parameter INIT_VAL, default 0, DATA_W-bit value written to every word during a clear.
REQ-006 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-007 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 en  input  1  request strobe; a request is accepted when en=1 and ready=1 at a rising edge.
REQ-010 r  input  1  request type: 1 is read, 0 is write.
REQ-011 address  input  ADDR_W  word address.
REQ-012 data  input  DATA_W  write data.
REQ-013 be  input  DATA_W/8  byte write enables; bit k enables data[8k+7:8k].
REQ-014 clr  input  1  request to re-run the full-array clear.
REQ-015 ready  output  1  high only in state IDLE; decoded from the state register.
REQ-016 out  output  DATA_W  read data.
REQ-017 out_valid  output  1  one-cycle pulse marking the cycle in which out carries new read data.

Function
REQ-018 FSM states SHALL be CLEAR and IDLE; there SHALL be no other states.
REQ-019 In CLEAR, each cycle SHALL write INIT_VAL to mem[clr_cnt] with all bytes enabled, then increment clr_cnt.
REQ-020 CLEAR SHALL last exactly DEPTH cycles (clr_cnt 0 to DEPTH-1); the state SHALL become IDLE on the edge that writes DEPTH-1.
REQ-021 clr_cnt SHALL reset to 0 on every entry to CLEAR.
REQ-022 In IDLE with clr=1, the next state SHALL be CLEAR; clr SHALL win over a simultaneous en, and that request SHALL NOT be accepted.
REQ-023 clr asserted during CLEAR SHALL be ignored; the clear SHALL NOT restart.
REQ-024 en asserted while ready=0 SHALL be ignored with no memory write and no out_valid; no request is queued.
REQ-025 An accepted write SHALL update only the bytes whose be bit is 1; be=0 SHALL leave the word unchanged and still count as accepted.
REQ-026 For an accepted read with OUT_REG=0, out=mem[address] and out_valid=1 SHALL appear on the accepting edge.
REQ-027 For an accepted read with OUT_REG=1, out and out_valid SHALL appear one edge after the accepting edge.
REQ-028 Back-to-back reads SHALL sustain one per cycle at both OUT_REG settings.
REQ-029 out SHALL hold its last value when no read completes; out_valid SHALL then be 0; out SHALL never drive Z.
REQ-030 A read already accepted before CLEAR entry SHALL complete with the pre-clear data.
REQ-031 A read of an address in the cycle after a write to it SHALL return the written data.
REQ-032 The data and be inputs SHALL be ignored for reads.

Reset
REQ-033 While rst_n=0: out=0, out_valid=0, the OUT_REG pipeline stage=0, clr_cnt=0.
REQ-034 While rst_n=0, state SHALL be CLEAR if CLEAR_ON_RESET=1, else IDLE; ready SHALL therefore reset to NOT CLEAR_ON_RESET.
REQ-035 Memory contents SHALL NOT be reset directly; with CLEAR_ON_RESET=0 they are undefined until written.
REQ-036 Reset asserted mid-clear SHALL abort the clear; with CLEAR_ON_RESET=1, a fresh clear from address 0 SHALL start after release.

Verification (defaults unless stated)
REQ-037 Release rst_n -> ready=0 for exactly 64 cycles, then ready=1; reading all 64 addresses returns 16'h0000.
REQ-038 Write 16'hA5C3 be=2'b11 to 6'h3F, then write 16'h1200 be=2'b10, then read 6'h3F -> out=16'h12C3 with out_valid pulse 1 cycle after acceptance.
REQ-039 OUT_REG=1 with reads to 0,1,2 on consecutive cycles -> out_valid high on 3 consecutive cycles, each 2 edges after its request, with the correct data.
REQ-040 clr and en write to 6'h05 asserted on the same IDLE edge -> write dropped, ready=0 for 64 cycles, then 6'h05 reads INIT_VAL.
REQ-041 Pulse rst_n low at clear cycle 30 -> after release, ready=0 for a full 64 cycles and out=0, out_valid=0 during reset.
REQ-042 Hold en=1 r=1 during CLEAR -> no out_valid; out keeps its previous value.
